// File: rtl/periph_arb_pkg.sv
// rtl/periph_arb_pkg.sv - shared types, constants and op-word decode for the peripheral lease arbiter
package periph_arb_pkg;

   typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

   localparam logic [3:0] CTRL_NIB = 4'hF;
   localparam logic [7:0] STOP_LO  = 8'hFF;

   function automatic logic is_ctrl(input logic [15:0] word, input logic [3:0] tag);
      return (word[15:12] == CTRL_NIB) && (word[11:8] == tag);
   endfunction

   function automatic logic is_start(input logic [15:0] word, input logic [3:0] tag);
      return is_ctrl(word, tag) && (word[7:4] == 4'h0) && (word[3:0] != 4'h0);
   endfunction

   function automatic logic is_stop(input logic [15:0] word, input logic [3:0] tag);
      return is_ctrl(word, tag) && (word[7:0] == STOP_LO);
   endfunction

   // Wrong-tag control-looking words fall through to data on purpose.
   function automatic logic is_data(input logic [15:0] word, input logic [3:0] tag);
      return !is_ctrl(word, tag) && (word != 16'h0000);
   endfunction

endpackage

// File: rtl/periph_arbiter_4n_if.sv
// rtl/periph_arbiter_4n_if.sv - node op buses and peripheral/status outputs of the lease arbiter
interface periph_arbiter_4n_if;
   logic [15:0] in_op_node0;
   logic [15:0] in_op_node1;
   logic [15:0] in_op_node2;
   logic [15:0] in_op_node3;
   logic [7:0]  out_peripheral;
   logic        owner_valid;
   logic [1:0]  owner_id;
   logic        timeout_evt;

   modport master (
      output in_op_node0, in_op_node1, in_op_node2, in_op_node3,
      input  out_peripheral, owner_valid, owner_id, timeout_evt
   );

   modport slave (
      input  in_op_node0, in_op_node1, in_op_node2, in_op_node3,
      output out_peripheral, owner_valid, owner_id, timeout_evt
   );
endinterface

// File: rtl/periph_req_pick.sv
// rtl/periph_req_pick.sv - combinational max-priority picker, ties resolved by scan order from rr_ptr
module periph_req_pick (
   input  logic [3:0][3:0] i_prio,
   input  logic [1:0]      i_rr_ptr,
   output logic            o_any_req,
   output logic [1:0]      o_winner
);

   logic [3:0] w_best;
   logic [1:0] w_idx;

   // Strict greater-than keeps the first tied node in scan order.
   always_comb begin
      w_best   = 4'h0;
      w_idx    = 2'd0;
      o_winner = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_idx = i_rr_ptr + 2'(k);
         if (i_prio[w_idx] > w_best) begin
            w_best   = i_prio[w_idx];
            o_winner = w_idx;
         end
      end
      o_any_req = (w_best != 4'h0);
   end

endmodule

// File: rtl/periph_arbiter_4n.sv
// rtl/periph_arbiter_4n.sv - four-node lease arbiter for one 8-bit output peripheral with lease watchdog
module periph_arbiter_4n
   import periph_arb_pkg::*;
#(
   parameter logic [3:0] TAG            = 4'b1010,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic               CLK,
   input  logic               RST,
   periph_arbiter_4n_if.slave bus
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state, w_state_n;
   logic [7:0]  r_out, w_out_n;
   logic        r_valid, w_valid_n;
   logic [1:0]  r_id, w_id_n;
   logic        r_evt, w_evt_n;
   logic [15:0] r_timer, w_timer_n;
   logic [1:0]  r_rr, w_rr_n;

   logic [15:0]     w_op [4];
   logic [3:0][3:0] w_prio;
   logic            w_any_req;
   logic [1:0]      w_winner;
   logic [15:0]     w_own_word;

   assign w_op[0] = bus.in_op_node0;
   assign w_op[1] = bus.in_op_node1;
   assign w_op[2] = bus.in_op_node2;
   assign w_op[3] = bus.in_op_node3;

   always_comb begin
      for (int i = 0; i < 4; i++)
         w_prio[i] = is_start(w_op[i], TAG) ? w_op[i][3:0] : 4'h0;
   end

   assign w_own_word = w_op[r_id];

   periph_req_pick u_pick (
      .i_prio    (w_prio),
      .i_rr_ptr  (r_rr),
      .o_any_req (w_any_req),
      .o_winner  (w_winner)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_out   <= 8'h00;
         r_valid <= 1'b0;
         r_id    <= 2'd0;
         r_evt   <= 1'b0;
         r_timer <= 16'h0000;
         r_rr    <= 2'd0;
      end else begin
         r_state <= w_state_n;
         r_out   <= w_out_n;
         r_valid <= w_valid_n;
         r_id    <= w_id_n;
         r_evt   <= w_evt_n;
         r_timer <= w_timer_n;
         r_rr    <= w_rr_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_out_n   = r_out;
      w_valid_n = r_valid;
      w_id_n    = r_id;
      w_evt_n   = 1'b0;
      w_timer_n = r_timer;
      w_rr_n    = r_rr;
      case (r_state)
         IDLE: begin
            w_out_n = 8'h00;
            if (w_any_req) begin
               w_state_n = OWN;
               w_id_n    = w_winner;
               w_valid_n = 1'b1;
               w_timer_n = 16'h0000;
            end
         end
         OWN: begin
            if (is_stop(w_own_word, TAG)) begin
               w_state_n = RELEASE;
               w_out_n   = 8'h00;
               w_valid_n = 1'b0;
            end else if (is_data(w_own_word, TAG)) begin
               w_out_n   = w_own_word[7:0];
               w_timer_n = 16'h0000;
            end else if (r_timer == TMO_LAST) begin
               w_state_n = RELEASE;
               w_out_n   = 8'h00;
               w_valid_n = 1'b0;
               w_evt_n   = 1'b1;
            end else begin
               w_timer_n = r_timer + 16'h0001;
            end
         end
         RELEASE: begin
            w_out_n   = 8'h00;
            w_valid_n = 1'b0;
            w_rr_n    = r_id + 2'd1;
            w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   assign bus.out_peripheral = r_out;
   assign bus.owner_valid    = r_valid;
   assign bus.owner_id       = r_id;
   assign bus.timeout_evt    = r_evt;

endmodule

// File: tb/tb_periph_arbiter_4n.sv
// tb/tb_periph_arbiter_4n.sv - directed self-checking bench for periph_arbiter_4n
module tb_periph_arbiter_4n;

   logic CLK;
   logic RST;
   int   total;
   int   bad;

   periph_arbiter_4n_if bus ();

   periph_arbiter_4n #(.TAG(4'b1010), .TIMEOUT_CYCLES(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic ops(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d);
      bus.in_op_node0 = a;
      bus.in_op_node1 = b;
      bus.in_op_node2 = c;
      bus.in_op_node3 = d;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic own(input string tag, input logic v, input logic [1:0] id, input logic [7:0] o);
      chk({tag, "_valid"}, 16'(v), 16'(bus.owner_valid));
      if (v) chk({tag, "_id"}, 16'(bus.owner_id), 16'(id));
      chk({tag, "_out"}, 16'(bus.out_peripheral), 16'(o));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      RST   = 1'b1;
      ops(16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      chk("rst_out", 16'(bus.out_peripheral), 16'h00);
      chk("rst_valid", 16'(bus.owner_valid), 16'h0);
      chk("rst_id", 16'(bus.owner_id), 16'h0);
      chk("rst_evt", 16'(bus.timeout_evt), 16'h0);
      RST = 1'b0;
      tick();

      // grant to node1, then data
      ops(16'h0, 16'hFA05, 16'h0, 16'h0);
      tick();
      own("g1", 1'b1, 2'd1, 8'h00);
      ops(16'h0, 16'h0042, 16'h0, 16'h0);
      tick();
      own("d1", 1'b1, 2'd1, 8'h42);
      ops(16'h0, 16'hFAFF, 16'h0, 16'h0);
      tick();
      own("stop1", 1'b0, 2'd0, 8'h00);
      ops(16'h0, 16'h0, 16'h0, 16'h0);
      tick();

      // higher priority wins; non-owner data ignored (rr_ptr=2)
      ops(16'hFA03, 16'h0, 16'hFA09, 16'h0);
      tick();
      own("prio", 1'b1, 2'd2, 8'h00);
      ops(16'h0011, 16'h0, 16'h0, 16'h0);
      tick();
      own("nonown", 1'b1, 2'd2, 8'h00);
      ops(16'h0, 16'h0, 16'hFAFF, 16'h0);
      tick();
      own("stop2", 1'b0, 2'd0, 8'h00);
      ops(16'hFAFF, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      own("idle_stop", 1'b0, 2'd0, 8'h00);

      // node3 lease moves rr_ptr to 0; non-owner stop ignored
      ops(16'h0, 16'h0, 16'h0, 16'hFA01);
      tick();
      own("g3", 1'b1, 2'd3, 8'h00);
      ops(16'hFAFF, 16'h0, 16'h0, 16'h0);
      tick();
      own("nonown_stop", 1'b1, 2'd3, 8'h00);
      ops(16'h0, 16'h0, 16'h0, 16'hFAFF);
      tick();
      ops(16'h0, 16'h0, 16'h0, 16'h0);
      tick();

      // tie at prio 7, rr_ptr=0 -> node1; after release rr_ptr=2 -> node3
      ops(16'h0, 16'hFA07, 16'h0, 16'hFA07);
      tick();
      own("tie_a", 1'b1, 2'd1, 8'h00);
      ops(16'h0, 16'hFAFF, 16'h0, 16'hFA07);
      tick();
      own("tie_rel", 1'b0, 2'd0, 8'h00);
      ops(16'h0, 16'hFA07, 16'h0, 16'hFA07);
      tick();
      own("no_regrant", 1'b0, 2'd0, 8'h00);
      tick();
      own("tie_b", 1'b1, 2'd3, 8'h00);
      ops(16'h0, 16'h0, 16'h0, 16'hFAFF);
      tick();
      ops(16'h0, 16'h0, 16'h0, 16'h0);
      tick();

      // watchdog with TIMEOUT_CYCLES=4; 16'h0100 is data and resets the timer
      ops(16'hFA02, 16'h0, 16'h0, 16'h0);
      tick();
      own("g0", 1'b1, 2'd0, 8'h00);
      ops(16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      tick();
      ops(16'h0100, 16'h0, 16'h0, 16'h0);
      tick();
      own("hi_data", 1'b1, 2'd0, 8'h00);
      ops(16'h0055, 16'h0, 16'h0, 16'h0);
      tick();
      own("d55", 1'b1, 2'd0, 8'h55);
      ops(16'h0, 16'h0, 16'h0, 16'h0);
      tick();
      tick();
      tick();
      own("idle3", 1'b1, 2'd0, 8'h55);
      chk("idle3_evt", 16'(bus.timeout_evt), 16'h0);
      tick();
      own("tmo", 1'b0, 2'd0, 8'h00);
      chk("tmo_evt", 16'(bus.timeout_evt), 16'h1);
      tick();
      chk("tmo_evt_clr", 16'(bus.timeout_evt), 16'h0);

      // wrong tag is data; prio-0 start and owner start are no-ops
      ops(16'h0, 16'hFA00, 16'hFA04, 16'h0);
      tick();
      own("g2", 1'b1, 2'd2, 8'h00);
      ops(16'h0, 16'h0, 16'hFB05, 16'h0);
      tick();
      own("wrong_tag", 1'b1, 2'd2, 8'h05);
      ops(16'h0, 16'h0, 16'hFA30, 16'h0);
      tick();
      own("noop", 1'b1, 2'd2, 8'h05);
      ops(16'h0, 16'h0, 16'hFA0F, 16'h0);
      tick();
      own("own_start", 1'b1, 2'd2, 8'h05);
      ops(16'h0, 16'h0, 16'h00AA, 16'h0);
      tick();
      own("dAA", 1'b1, 2'd2, 8'hAA);

      // asynchronous reset mid-lease
      #2;
      RST = 1'b1;
      #1;
      own("arst", 1'b0, 2'd0, 8'h00);
      chk("arst_id", 16'(bus.owner_id), 16'h0);
      chk("arst_evt", 16'(bus.timeout_evt), 16'h0);
      tick();
      RST = 1'b0;
      ops(16'h0, 16'h0, 16'h0, 16'hFA01);
      tick();
      own("post_rst", 1'b1, 2'd3, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
